// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch queue.
//   INSTR_BYTES    bytes per instruction word (little-endian, word aligned)
//   FE_*_WIDTH     default address / instruction widths of a queue entry
//   fetch_entry_t  one buffered instruction: its address and its word
//   fetch_state_e  fetch FSM states (FETCH streams groups, HALT waits for a
//                  redirect after running off the end of the ROM)
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int INSTR_BYTES   = 4;
    localparam int FE_ADDR_WIDTH = 32;
    localparam int FE_DATA_WIDTH = 32;

    typedef struct packed {
        logic [FE_ADDR_WIDTH-1:0] addr;
        logic [FE_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Circular buffer holding fetched instructions between fetch and decode.
// Up to WIDTH entries are written at the tail and up to WIDTH entries are
// retired from the head every cycle. The caller guarantees it never writes
// more than the free space and never retires more than the occupancy.
// Ports:
//   clk, rst_n     clock / asynchronous active-low reset
//   flush_i        empty the queue; same-cycle writes and retires are dropped
//   enq_cnt_i      number of leading enq_data_i slots to append
//   enq_data_i     WIDTH candidate entries, slot 0 is appended first
//   deq_cnt_i      number of entries retired from the head
//   head_data_o    the WIDTH oldest storage locations (validity is count_o)
//   count_o        occupied entries
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH   = 8,
    parameter int WIDTH   = 2,
    parameter int ENTRY_W = 64,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = $clog2(DEPTH) + 1,
    localparam int SLOT_CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush_i,
    input  logic [SLOT_CNT_W-1:0]           enq_cnt_i,
    input  logic [WIDTH-1:0][ENTRY_W-1:0]   enq_data_i,
    input  logic [SLOT_CNT_W-1:0]           deq_cnt_i,
    output logic [WIDTH-1:0][ENTRY_W-1:0]   head_data_o,
    output logic [CNT_W-1:0]                count_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Pointer and occupancy update. Pointers are exactly log2(DEPTH) bits so
    // they wrap around the ring for free; a flush simply rewinds everything.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(deq_cnt_i);
            tail_d  = tail_q + PTR_W'(enq_cnt_i);
            count_d = count_q + CNT_W'(enq_cnt_i) - CNT_W'(deq_cnt_i);
        end
    end

    // Control registers; reset discards all queued entries at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset: an entry is only ever looked at once count says
    // it was written, so stale contents are harmless.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WIDTH; k++) begin
            if (!flush_i && (int'(enq_cnt_i) > k)) begin
                mem_q[tail_q + PTR_W'(k)] <= enq_data_i[k];
            end
        end
    end

    // Present the oldest WIDTH locations starting at head, wrapping the ring.
    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            head_data_o[k] = mem_q[head_q + PTR_W'(k)];
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
// Fetch stage: holds the fetch PC, reads FETCH_WIDTH consecutive words per
// cycle from the ROM image, cuts the group at a predicted-taken slot or at the
// end of the ROM, and buffers the words for decode in fetch_queue.
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   instr_data        ROM image, byte i = instr_data[i*8 +: 8]
//   fetch_pc          current fetch PC (drives the predictor lookup)
//   predict_taken     a slot of the current group is predicted taken
//   predict_slot      index of that slot
//   predict_target    predicted target PC
//   redirect_valid    backend flush; wins over everything else
//   redirect_pc       PC to restart from after a redirect
//   deq_valid         slot k holds the k-th oldest queued instruction
//   deq_ready         decode accepts slot k (only a ready prefix retires)
//   deq_instr         slot k instruction, 0 when slot k is not valid
//   deq_addr          slot k address, 0 when slot k is not valid
//   queue_count       occupied queue entries
//   fetch_halted      fetch ran off the ROM and waits for a redirect
// ---------------------------------------------------------------------------
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int INSTR_MEM_SIZE = 4096,
    parameter int FETCH_WIDTH    = 2,
    parameter int QUEUE_DEPTH    = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    localparam int SLOT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
    localparam int CNT_W  = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [INSTR_MEM_SIZE*8-1:0]       instr_data,
    output logic [ADDR_WIDTH-1:0]             fetch_pc,
    input  logic                              predict_taken,
    input  logic [SLOT_W-1:0]                 predict_slot,
    input  logic [ADDR_WIDTH-1:0]             predict_target,
    input  logic                              redirect_valid,
    input  logic [ADDR_WIDTH-1:0]             redirect_pc,
    output logic [FETCH_WIDTH-1:0]            deq_valid,
    input  logic [FETCH_WIDTH-1:0]            deq_ready,
    output logic [FETCH_WIDTH*DATA_WIDTH-1:0] deq_instr,
    output logic [FETCH_WIDTH*ADDR_WIDTH-1:0] deq_addr,
    output logic [CNT_W-1:0]                  queue_count,
    output logic                              fetch_halted
);

    localparam int LEN_W     = $clog2(FETCH_WIDTH) + 1;
    localparam int ENTRY_W   = ADDR_WIDTH + DATA_WIDTH;
    localparam int MEM_AW    = $clog2(INSTR_MEM_SIZE);
    localparam int ROM_BIT_W = MEM_AW + 3;

    fetch_state_e                           state_q, state_d;
    logic [ADDR_WIDTH-1:0]                  fetchPc_q, fetchPc_d;

    logic [FETCH_WIDTH-1:0][ADDR_WIDTH:0]   slotAddrExt;
    logic [FETCH_WIDTH-1:0][ADDR_WIDTH-1:0] slotAddr;
    logic [FETCH_WIDTH-1:0]                 slotInRange;
    logic [FETCH_WIDTH-1:0][ROM_BIT_W-1:0]  romBitIdx;
    logic [FETCH_WIDTH-1:0][ENTRY_W-1:0]    enqData;

    logic [LEN_W-1:0]                       rangeLen;
    logic [LEN_W-1:0]                       groupLen;
    logic                                   takenInRange;
    logic                                   haveSpace;
    logic [LEN_W-1:0]                       enqCnt;
    logic [LEN_W-1:0]                       deqCnt;
    logic                                   deqStop;
    logic                                   flush;

    logic [CNT_W-1:0]                       count;
    logic [FETCH_WIDTH-1:0][ENTRY_W-1:0]    headData;
    logic [FETCH_WIDTH-1:0]                 deqValid;

    // Slot addresses and ROM reads. The address is widened by one bit so a
    // group that wraps past the top of the address space can never look like
    // an in-range word. The ROM is word aligned and little-endian, so the
    // word at byte a is simply the 32 bits starting at bit 8*a.
    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            slotAddrExt[i] = {1'b0, fetchPc_q} + (ADDR_WIDTH+1)'(INSTR_BYTES * i);
            slotAddr[i]    = slotAddrExt[i][ADDR_WIDTH-1:0];
            slotInRange[i] = (slotAddrExt[i][1:0] == 2'b00) &&
                             ((slotAddrExt[i] + (ADDR_WIDTH+1)'(INSTR_BYTES)) <=
                              (ADDR_WIDTH+1)'(INSTR_MEM_SIZE));
            romBitIdx[i]   = {slotAddr[i][MEM_AW-1:2], 5'b00000};
            enqData[i]     = {slotAddr[i], instr_data[romBitIdx[i] +: DATA_WIDTH]};
        end
    end

    // Group length: stop at the first word outside the ROM, then cut after
    // the predicted-taken slot if that slot comes first. A taken slot past
    // the in-range prefix is not followed, since fetch never reached it.
    always_comb begin
        rangeLen = LEN_W'(FETCH_WIDTH);
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (!slotInRange[i]) begin
                rangeLen = LEN_W'(i);
            end
        end
        takenInRange = predict_taken && (int'(predict_slot) < int'(rangeLen));
        groupLen     = takenInRange ? (LEN_W'(predict_slot) + LEN_W'(1)) : rangeLen;
        haveSpace    = (QUEUE_DEPTH - int'(count)) >= FETCH_WIDTH;
    end

    // Fetch FSM next state. A group is only written when a full FETCH_WIDTH
    // of space was free at the start of the cycle, so retires in the same
    // cycle never need to be taken into account. Hitting the ROM end before
    // any taken slot parks the FSM in HALT until the backend redirects.
    always_comb begin
        state_d   = state_q;
        fetchPc_d = fetchPc_q;
        enqCnt    = '0;
        flush     = 1'b0;
        if (redirect_valid) begin
            flush     = 1'b1;
            state_d   = FETCH;
            fetchPc_d = redirect_pc;
        end else begin
            case (state_q)
                FETCH: begin
                    if (haveSpace) begin
                        if (!slotInRange[0]) begin
                            state_d = HALT;
                        end else begin
                            enqCnt    = groupLen;
                            fetchPc_d = takenInRange ? predict_target :
                                        fetchPc_q + ADDR_WIDTH'(INSTR_BYTES * FETCH_WIDTH);
                            if (!takenInRange && (int'(rangeLen) < FETCH_WIDTH)) begin
                                state_d = HALT;
                            end
                        end
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    // PC and state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            fetchPc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            fetchPc_q <= fetchPc_d;
        end
    end

    // Decode handshake: slot k is valid when k entries precede it, and only
    // an unbroken prefix of valid&ready slots retires this cycle.
    always_comb begin
        deqCnt    = '0;
        deqStop   = 1'b0;
        deq_instr = '0;
        deq_addr  = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            deqValid[k] = int'(count) > k;
            if (!deqStop && deqValid[k] && deq_ready[k]) begin
                deqCnt = deqCnt + LEN_W'(1);
            end else begin
                deqStop = 1'b1;
            end
            deq_instr[k*DATA_WIDTH +: DATA_WIDTH] =
                deqValid[k] ? headData[k][DATA_WIDTH-1:0] : '0;
            deq_addr[k*ADDR_WIDTH +: ADDR_WIDTH] =
                deqValid[k] ? headData[k][ENTRY_W-1:DATA_WIDTH] : '0;
        end
    end

    fetch_queue #(
        .DEPTH   (QUEUE_DEPTH),
        .WIDTH   (FETCH_WIDTH),
        .ENTRY_W (ENTRY_W)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .enq_cnt_i   (enqCnt),
        .enq_data_i  (enqData),
        .deq_cnt_i   (deqCnt),
        .head_data_o (headData),
        .count_o     (count)
    );

    assign fetch_pc     = fetchPc_q;
    assign deq_valid    = deqValid;
    assign queue_count  = count;
    assign fetch_halted = (state_q == HALT);

endmodule
